// File: rtl/npu_defines.sv
// npu_defines: shared thread mask, refill FSM state and beat counter types for the icache refill engine
package npu_defines;
    localparam int THREAD_NUMB = 4;
    typedef logic [THREAD_NUMB-1:0] thread_mask_t;
    localparam int ICACHE_REFILL_BEAT_W = 64;
    localparam int ICACHE_REFILL_BEATS = 8;
    localparam int ICACHE_REFILL_LINE_W = ICACHE_REFILL_BEATS * ICACHE_REFILL_BEAT_W;
    typedef logic [$clog2(ICACHE_REFILL_BEATS)-1:0] icache_beat_cnt_t;
    typedef enum logic [1:0] {IDLE, REQ, WAIT_DATA, DELIVER} icache_refill_state_t;
endpackage

// File: rtl/icache_refill_line_buffer.sv
// icache_refill_line_buffer: assembles memory beats into a line and publishes it when the last beat lands
module icache_refill_line_buffer #(
    parameter int LINE_W = 512,
    parameter int BEAT_W = 64
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 wr_en,
    input  logic [$clog2(LINE_W/BEAT_W)-1:0]     wr_idx,
    input  logic [BEAT_W-1:0]                    wr_data,
    output logic [LINE_W-1:0]                    line_out
);
    localparam int BEATS = LINE_W / BEAT_W;
    localparam int IDX_W = $clog2(BEATS);

    logic [LINE_W-BEAT_W-1:0] asm_q;
    logic last;

    assign last = wr_en && (wr_idx == IDX_W'(BEATS - 1));

    // Early beats accumulate privately; the last beat publishes the full line so the output holds until the next refill completes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            asm_q <= '0;
            line_out <= '0;
        end else begin
            if (wr_en && !last) asm_q[int'(wr_idx)*BEAT_W +: BEAT_W] <= wr_data;
            if (last) line_out <= {wr_data, asm_q};
        end
    end
endmodule

// File: rtl/icache_refill_engine.sv
// icache_refill_engine: serves the head icache miss with a line read and delivers the refilled line (optional watchdog: ICACHE_REFILL_TIMEOUT_EN)
module icache_refill_engine
    import npu_defines::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = ICACHE_REFILL_LINE_W,
    parameter int BEAT_W = ICACHE_REFILL_BEAT_W
`ifdef ICACHE_REFILL_TIMEOUT_EN
    , parameter int TIMEOUT_CYCLES = 1024
`endif
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   enable,
    input  logic                   pending_in,
    input  logic [ADDR_W-1:0]      address_in,
    input  logic [THREAD_NUMB-1:0] thread_oh_in,
    output logic                   dequeue_out,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [ADDR_W-1:0]      mem_req_address,
    input  logic                   mem_rsp_valid,
    input  logic [BEAT_W-1:0]      mem_rsp_data,
    output logic                   refill_valid,
    output logic [ADDR_W-1:0]      refill_address,
    output logic [LINE_W-1:0]      refill_data,
    output logic [THREAD_NUMB-1:0] refill_thread_oh,
    output logic                   busy
`ifdef ICACHE_REFILL_TIMEOUT_EN
    , output logic                 refill_timeout_o
`endif
);
    localparam int BEATS = LINE_W / BEAT_W;
    localparam int CNT_W = $clog2(BEATS);

    icache_refill_state_t state, next_state;
    logic [ADDR_W-1:0] addr_q;
    logic [CNT_W-1:0] beat_cnt;
    logic full, capture, last, done, tmo_fire;

    // Beats are taken whenever WAIT_DATA is active, even while the FSM is held, because memory cannot stall
    assign capture = (state == WAIT_DATA) && mem_rsp_valid && !full;
    assign last = capture && (beat_cnt == CNT_W'(BEATS - 1));
    assign done = full || last;

    assign mem_req_valid = (state == REQ);
    assign mem_req_address = addr_q;
    assign refill_valid = (state == DELIVER);
    assign dequeue_out = (state == DELIVER);
    assign refill_thread_oh = (state == DELIVER) ? thread_oh_in : '0;
    assign busy = (state != IDLE);

`ifdef ICACHE_REFILL_TIMEOUT_EN
    logic [15:0] wd_cnt;
    assign tmo_fire = (state == WAIT_DATA) && !capture && !full && (wd_cnt >= 16'(TIMEOUT_CYCLES - 1));
    // Watchdog counts beat-less WAIT_DATA cycles and latches a sticky flag whenever it forces a re-issue
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt <= '0;
            refill_timeout_o <= 1'b0;
        end else begin
            wd_cnt <= (state != WAIT_DATA || capture) ? '0 : (wd_cnt != 16'hffff) ? wd_cnt + 16'd1 : wd_cnt;
            if (enable && tmo_fire) refill_timeout_o <= 1'b1;
        end
    end
`else
    assign tmo_fire = 1'b0;
`endif

    // Next-state: one miss at a time, DELIVER always lasts a single enabled cycle
    always_comb begin
        next_state = state;
        case (state)
            IDLE:      next_state = pending_in ? REQ : IDLE;
            REQ:       next_state = mem_req_ready ? WAIT_DATA : REQ;
            WAIT_DATA: next_state = done ? DELIVER : tmo_fire ? REQ : WAIT_DATA;
            default:   next_state = IDLE;
        endcase
    end

    // State, line-aligned address latch, delivered address and beat bookkeeping
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            addr_q <= '0;
            refill_address <= '0;
            beat_cnt <= '0;
            full <= 1'b0;
        end else begin
            if (enable) state <= next_state;
            if (enable && state == IDLE && pending_in) addr_q <= address_in & ~ADDR_W'(LINE_W / 8 - 1);
            if (enable && state == WAIT_DATA && done) refill_address <= addr_q;
            beat_cnt <= (enable && tmo_fire) ? '0 : capture ? beat_cnt + CNT_W'(1) : beat_cnt;
            full <= (state == WAIT_DATA) && (full || last) && !enable;
        end
    end

    icache_refill_line_buffer #(
        .LINE_W(LINE_W),
        .BEAT_W(BEAT_W)
    ) u_line_buffer (
        .clk(clk),
        .reset(reset),
        .wr_en(capture),
        .wr_idx(beat_cnt),
        .wr_data(mem_rsp_data),
        .line_out(refill_data)
    );
endmodule

// File: tb/tb_icache_refill_engine.sv
// tb_icache_refill_engine: directed refill scenarios checked against a transaction-level model every cycle
module tb_icache_refill_engine;
    localparam int BEATS = 8;
    localparam int TMO = 16;
`ifdef ICACHE_REFILL_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset, enable, pending_in, mem_req_ready, mem_rsp_valid;
    logic [31:0] address_in;
    logic [3:0] thread_oh_in;
    logic [63:0] mem_rsp_data;
    logic dequeue_out, mem_req_valid, refill_valid, busy;
    logic [31:0] mem_req_address, refill_address;
    logic [511:0] refill_data;
    logic [3:0] refill_thread_oh;
    logic refill_timeout_o;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    always #5 clk = ~clk;

    icache_refill_engine #(
        .ADDR_W(32), .LINE_W(512), .BEAT_W(64)
`ifdef ICACHE_REFILL_TIMEOUT_EN
        , .TIMEOUT_CYCLES(TMO)
`endif
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .pending_in(pending_in),
        .address_in(address_in), .thread_oh_in(thread_oh_in), .dequeue_out(dequeue_out),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_address(mem_req_address),
        .mem_rsp_valid(mem_rsp_valid), .mem_rsp_data(mem_rsp_data), .refill_valid(refill_valid),
        .refill_address(refill_address), .refill_data(refill_data), .refill_thread_oh(refill_thread_oh),
        .busy(busy)
`ifdef ICACHE_REFILL_TIMEOUT_EN
        , .refill_timeout_o(refill_timeout_o)
`endif
    );
`ifndef ICACHE_REFILL_TIMEOUT_EN
    assign refill_timeout_o = 1'b0;
`endif

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: 0 no miss, 1 asking memory, 2 collecting beats, 3 handing line over
    int m_stage = 0, m_n = 0, m_quiet = 0;
    bit m_tmo = 0;
    logic [31:0] m_addr, m_raddr;
    logic [63:0] m_beats [BEATS];
    logic [511:0] m_line;

    always @(posedge clk) begin
        cyc++;
        if (reset) begin
            m_stage = 0; m_n = 0; m_quiet = 0; m_tmo = 0;
        end else begin
            if (m_stage == 2 && m_n < BEATS) begin
                if (mem_rsp_valid) begin m_beats[m_n] = mem_rsp_data; m_n++; m_quiet = 0; end
                else m_quiet++;
            end
            if (enable) begin
                if (m_stage == 0) begin
                    if (pending_in) begin m_addr = address_in - (address_in % 64); m_stage = 1; end
                end else if (m_stage == 1) begin
                    if (mem_req_ready) begin m_stage = 2; m_n = 0; m_quiet = 0; end
                end else if (m_stage == 2) begin
                    if (m_n == BEATS) begin
                        for (int k = 0; k < BEATS; k++) m_line[k*64 +: 64] = m_beats[k];
                        m_raddr = m_addr;
                        m_stage = 3;
                    end else if (TMO_EN && m_quiet >= TMO) begin
                        m_stage = 1; m_tmo = 1;
                    end
                end else m_stage = 0;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (reset) begin
            check("rst_busy", busy, 0);
            check("rst_req_valid", mem_req_valid, 0);
            check("rst_req_addr", mem_req_address, 0);
            check("rst_refill_valid", refill_valid, 0);
            check("rst_dequeue", dequeue_out, 0);
            check("rst_refill_addr", refill_address, 0);
            check("rst_refill_data", refill_data, 0);
            check("rst_thread", refill_thread_oh, 0);
            check("rst_timeout", refill_timeout_o, 0);
        end else begin
            check("busy", busy, m_stage != 0);
            check("req_valid", mem_req_valid, m_stage == 1);
            if (m_stage == 1) check("req_addr", mem_req_address, m_addr);
            check("refill_valid", refill_valid, m_stage == 3);
            check("dequeue", dequeue_out, m_stage == 3);
            check("thread", refill_thread_oh, (m_stage == 3) ? thread_oh_in : 4'b0);
            check("timeout", refill_timeout_o, m_tmo);
            if (m_stage == 3) begin
                check("refill_addr", refill_address, m_raddr);
                check("refill_data", refill_data, m_line);
            end
        end
    end

    task automatic send_beats(input int base, input int n);
        for (int k = 0; k < n; k++) begin
            mem_rsp_valid = 1'b1;
            mem_rsp_data = 64'(base + k);
            @(negedge clk);
        end
        mem_rsp_valid = 1'b0;
    endtask

    task automatic beat_is(input string name, input int k, input int exp);
        logic [511:0] d;
        d = refill_data;
        check(name, d[k*64 +: 64], 64'(exp));
    endtask

    initial begin
        int t0, nreq;
        reset = 1; enable = 1; pending_in = 1; address_in = 32'h0000_1234; thread_oh_in = 4'b0001;
        mem_req_ready = 1; mem_rsp_valid = 0; mem_rsp_data = '0;
        repeat (3) @(negedge clk);
        reset = 0;
        t0 = cyc + 1;
        @(negedge clk);
        check("t2_req_valid", mem_req_valid, 1);
        check("t2_req_addr", mem_req_address, 32'h0000_1200);
        pending_in = 0;
        @(negedge clk);
        send_beats(0, 8);
        check("t2_refill_valid", refill_valid, 1);
        check("t2_dequeue", dequeue_out, 1);
        check("t2_latency", cyc - t0 + 1, 10);
        for (int k = 0; k < 8; k++) beat_is("t2_beat", k, k);
        check("t2_refill_addr", refill_address, 32'h0000_1200);
        @(negedge clk);
        check("t2_single_pulse", refill_valid, 0);
        check("t2_idle", busy, 0);

        pending_in = 1; address_in = 32'h0000_ABCD; mem_req_ready = 0;
        @(negedge clk);
        pending_in = 0;
        nreq = 0;
        for (int i = 0; i < 6; i++) begin
            mem_req_ready = (i == 5);
            if (mem_req_valid && mem_req_address == 32'h0000_ABC0) nreq++;
            @(negedge clk);
        end
        check("t3_req_cycles", nreq, 6);
        check("t3_single_accept", mem_req_valid, 0);
        thread_oh_in = 4'b0101;
        send_beats(100, 8);
        check("t4_thread", refill_thread_oh, 4'b0101);
        beat_is("t3_beat3", 3, 103);
        @(negedge clk);
        thread_oh_in = 4'b0001;

        pending_in = 1; address_in = 32'h0000_4444; mem_req_ready = 1;
        @(negedge clk);
        pending_in = 0;
        @(negedge clk);
        send_beats(200, 3);
        enable = 0;
        send_beats(203, 5);
        @(negedge clk);
        check("t5_held_no_refill", refill_valid, 0);
        check("t5_held_busy", busy, 1);
        enable = 1;
        @(negedge clk);
        check("t5_refill_valid", refill_valid, 1);
        beat_is("t5_beat0", 0, 200);
        beat_is("t5_beat7", 7, 207);
        check("t5_refill_addr", refill_address, 32'h0000_4440);
        @(negedge clk);

`ifdef ICACHE_REFILL_TIMEOUT_EN
        pending_in = 1; address_in = 32'h0000_5000;
        @(negedge clk);
        pending_in = 0;
        @(negedge clk);
        repeat (TMO) @(negedge clk);
        check("t6_reissue", mem_req_valid, 1);
        check("t6_reissue_addr", mem_req_address, 32'h0000_5000);
        check("t6_sticky", refill_timeout_o, 1);
        @(negedge clk);
        send_beats(300, 8);
        check("t6_refill_valid", refill_valid, 1);
        beat_is("t6_beat0", 0, 300);
        @(negedge clk);
`endif

        pending_in = 1; address_in = 32'h0000_2000;
        @(negedge clk);
        pending_in = 0;
        @(negedge clk);
        send_beats(400, 3);
        reset = 1; mem_rsp_valid = 1; mem_rsp_data = 64'd999;
        @(negedge clk);
        check("t7_abort_busy", busy, 0);
        check("t7_abort_data", refill_data, 0);
        reset = 0;
        @(negedge clk);
        @(negedge clk);
        check("t7_stray_ignored", busy, 0);
        mem_rsp_valid = 0;
        pending_in = 1; address_in = 32'h0000_3040;
        @(negedge clk);
        pending_in = 0;
        @(negedge clk);
        send_beats(500, 8);
        check("t7_refill_valid", refill_valid, 1);
        beat_is("t7_beat0", 0, 500);
        check("t7_refill_addr", refill_address, 32'h0000_3040);
        repeat (2) @(negedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
